// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state one-hot ring with a separate HALT flag.
// The control word is decoded combinationally from the ring state and the IR opcode.
module sap1_controller (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] ir_opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       halted,
    output logic [5:0] t_state
);
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    logic [5:0] ring_q;
    logic [5:0] ring_d;
    logic       halt_q;
    logic       halt_d;
    logic       legal;
    ctrl_t      ctrl;

    assign legal = $onehot(ring_q);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ring_q <= 6'b000001;
            halt_q <= 1'b0;
        end else begin
            ring_q <= ring_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        ring_d = ring_q;
        halt_d = halt_q;
        if (halt_q) begin
            ring_d = ring_q;
        end else if (!legal) begin
            ring_d = 6'b000001;
        end else if (ring_q[3] && ir_opcode == OP_HLT) begin
            halt_d = 1'b1;
        end else begin
            ring_d = {ring_q[4:0], ring_q[5]};
        end
    end

    // Gating on clr_n makes reset kill every control immediately, mid-cycle.
    always_comb begin
        ctrl = '0;
        if (clr_n && !halt_q && legal) begin
            unique case (1'b1)
                ring_q[0]: begin
                    ctrl.ep = 1'b1;
                    ctrl.lm = 1'b1;
                end
                ring_q[1]: ctrl.cp = 1'b1;
                ring_q[2]: begin
                    ctrl.ce = 1'b1;
                    ctrl.li = 1'b1;
                end
                ring_q[3]: begin
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.ei = 1'b1;
                            ctrl.lm = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.ea = 1'b1;
                            ctrl.lo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ring_q[4]: begin
                    case (ir_opcode)
                        OP_LDA: begin
                            ctrl.ce = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        OP_ADD: begin
                            ctrl.ce = 1'b1;
                            ctrl.lb = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl.ce = 1'b1;
                            ctrl.lb = 1'b1;
                            ctrl.su = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ring_q[5]: begin
                    case (ir_opcode)
                        OP_ADD: begin
                            ctrl.eu = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl.eu = 1'b1;
                            ctrl.su = 1'b1;
                            ctrl.la = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign cp      = ctrl.cp;
    assign ep      = ctrl.ep;
    assign lm      = ctrl.lm;
    assign ce      = ctrl.ce;
    assign li      = ctrl.li;
    assign ei      = ctrl.ei;
    assign la      = ctrl.la;
    assign ea      = ctrl.ea;
    assign su      = ctrl.su;
    assign eu      = ctrl.eu;
    assign lb      = ctrl.lb;
    assign lo      = ctrl.lo;
    assign halted  = halt_q;
    assign t_state = halt_q ? 6'b000000 : ring_q;
endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: stimulus pushes expected control words,
// a monitor pops and compares at each negedge or on an explicit mid-cycle sample.
module tb_sap1_controller;
    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted;
    logic [5:0] t_state;

    sap1_controller dut (
        .clk(clk), .clr_n(clr_n), .ir_opcode(ir_opcode),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
        .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
        .halted(halted), .t_state(t_state)
    );

    always #5 clk = ~clk;

    // Control word bit order: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam logic [11:0] CP = 12'h800;
    localparam logic [11:0] EP = 12'h400;
    localparam logic [11:0] LM = 12'h200;
    localparam logic [11:0] CE = 12'h100;
    localparam logic [11:0] LI = 12'h080;
    localparam logic [11:0] EI = 12'h040;
    localparam logic [11:0] LA = 12'h020;
    localparam logic [11:0] EA = 12'h010;
    localparam logic [11:0] SU = 12'h008;
    localparam logic [11:0] EU = 12'h004;
    localparam logic [11:0] LB = 12'h002;
    localparam logic [11:0] LO = 12'h001;

    typedef struct {
        logic [5:0]  t;
        logic        h;
        logic [11:0] c;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    event sample_now;

    wire [11:0] ctrl_w = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    wire [4:0]  drv_w  = {ep, ce, ei, ea, eu};

    initial begin
        forever begin
            @(negedge clk or sample_now);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if (t_state !== e.t) begin
                    fails++;
                    $display("FAIL %s t_state got %h exp %h", e.name, t_state, e.t);
                end
                tests++;
                if (halted !== e.h) begin
                    fails++;
                    $display("FAIL %s halted got %b exp %b", e.name, halted, e.h);
                end
                tests++;
                if (ctrl_w !== e.c) begin
                    fails++;
                    $display("FAIL %s ctrl got %h exp %h", e.name, ctrl_w, e.c);
                end
                tests++;
                if ($countones(drv_w) > 1) begin
                    fails++;
                    $display("FAIL %s bus drivers got %b exp onehot0", e.name, drv_w);
                end
            end
        end
    end

    task automatic cycle(input logic rst_v, input logic [3:0] op,
                         input logic [5:0] t, input logic h,
                         input logic [11:0] c, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        clr_n = rst_v;
        ir_opcode = op;
        e.t = t;
        e.h = h;
        e.c = c;
        e.name = name;
        sb.push_back(e);
    endtask

    // Runs T2..T6 of an instruction and the following T1.
    task automatic instr(input logic [3:0] op, input logic [11:0] c4,
                         input logic [11:0] c5, input logic [11:0] c6,
                         input string name);
        cycle(1'b1, op, 6'h02, 1'b0, CP, {name, "_t2"});
        cycle(1'b1, op, 6'h04, 1'b0, CE | LI, {name, "_t3"});
        cycle(1'b1, op, 6'h08, 1'b0, c4, {name, "_t4"});
        cycle(1'b1, op, 6'h10, 1'b0, c5, {name, "_t5"});
        cycle(1'b1, op, 6'h20, 1'b0, c6, {name, "_t6"});
        cycle(1'b1, op, 6'h01, 1'b0, EP | LM, {name, "_t1"});
    endtask

    function automatic logic [11:0] exec_word(input int t, input logic [3:0] op);
        logic [11:0] w;
        w = '0;
        case (op)
            4'h0: w = (t == 4) ? (EI | LM) : (t == 5) ? (CE | LA) : 12'h000;
            4'h1: w = (t == 4) ? (EI | LM) : (t == 5) ? (CE | LB) : (EU | LA);
            4'h2: w = (t == 4) ? (EI | LM) : (t == 5) ? (CE | LB | SU) : (EU | SU | LA);
            4'hE: w = (t == 4) ? (EA | LO) : 12'h000;
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    initial begin
        int guard;
        logic [3:0] rop;
        cycle(1'b0, 4'h0, 6'h01, 1'b0, 12'h000, "reset_a");
        cycle(1'b0, 4'h0, 6'h01, 1'b0, 12'h000, "reset_b");
        cycle(1'b1, 4'h0, 6'h01, 1'b0, EP | LM, "release_t1");

        instr(4'h0, EI | LM, CE | LA, 12'h000, "lda");
        instr(4'h2, EI | LM, CE | LB | SU, EU | SU | LA, "sub");
        instr(4'h1, EI | LM, CE | LB, EU | LA, "add");
        instr(4'hE, EA | LO, 12'h000, 12'h000, "out");
        instr(4'h7, 12'h000, 12'h000, 12'h000, "undef");

        // Asynchronous reset in the second half of ADD's T6
        cycle(1'b1, 4'h1, 6'h02, 1'b0, CP, "abort_t2");
        cycle(1'b1, 4'h1, 6'h04, 1'b0, CE | LI, "abort_t3");
        cycle(1'b1, 4'h1, 6'h08, 1'b0, EI | LM, "abort_t4");
        cycle(1'b1, 4'h1, 6'h10, 1'b0, CE | LB, "abort_t5");
        cycle(1'b1, 4'h1, 6'h20, 1'b0, EU | LA, "abort_t6");
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        begin
            exp_t e;
            e.t = 6'h01; e.h = 1'b0; e.c = 12'h000; e.name = "abort_async";
            sb.push_back(e);
        end
        #1;
        -> sample_now;
        cycle(1'b0, 4'h1, 6'h01, 1'b0, 12'h000, "abort_held");
        cycle(1'b1, 4'h1, 6'h01, 1'b0, EP | LM, "abort_rel_t1");

        // HLT, then toggle opcode while halted
        cycle(1'b1, 4'hF, 6'h02, 1'b0, CP, "hlt_t2");
        cycle(1'b1, 4'hF, 6'h04, 1'b0, CE | LI, "hlt_t3");
        cycle(1'b1, 4'hF, 6'h08, 1'b0, 12'h000, "hlt_t4");
        for (int i = 0; i < 22; i++) begin
            rop = 4'(i);
            cycle(1'b1, rop, 6'h00, 1'b1, 12'h000, "halted");
        end
        cycle(1'b0, 4'h0, 6'h01, 1'b0, 12'h000, "hlt_clr");
        cycle(1'b1, 4'h0, 6'h01, 1'b0, EP | LM, "hlt_exit_t1");

        // Random non-HLT opcodes
        for (int n = 0; n < 1000; n++) begin
            rop = 4'($urandom_range(0, 14));
            cycle(1'b1, rop, 6'h02, 1'b0, CP, "rnd_t2");
            cycle(1'b1, rop, 6'h04, 1'b0, CE | LI, "rnd_t3");
            cycle(1'b1, rop, 6'h08, 1'b0, exec_word(4, rop), "rnd_t4");
            cycle(1'b1, rop, 6'h10, 1'b0, exec_word(5, rop), "rnd_t5");
            cycle(1'b1, rop, 6'h20, 1'b0, exec_word(6, rop), "rnd_t6");
            cycle(1'b1, rop, 6'h01, 1'b0, EP | LM, "rnd_t1");
        end

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain queue got %0d left exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
